// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one registered BRAM bus port between N_REQ requesters,
// with burst locking. Optional lock watchdog enabled by CPU_BUS_ARB_WATCHDOG_EN.
module cpu_bus_arbiter #(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  BUS_CLK,
    input  logic                  RST_N,
    input  logic [N_REQ-1:0]      REQ_VALID,
    output logic [N_REQ-1:0]      REQ_READY,
    input  logic [N_REQ-1:0]      REQ_LAST,
    input  logic [N_REQ-1:0]      REQ_WE,
    input  logic [2*N_REQ-1:0]    REQ_SELECT,
    input  logic [14*N_REQ-1:0]   REQ_ADDR,
    input  logic [16*N_REQ-1:0]   REQ_DATA,
    output logic                  EN,
    output logic                  WE,
    output logic [1:0]            BRAM_SELECT,
    output logic [13:0]           BRAM_ADDR,
    output logic [15:0]           DATA_IN,
    output logic [N_REQ-1:0]      GRANT,
    output logic                  TIMEOUT_FLAG
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    typedef logic [IdxW-1:0] idx_t;
    typedef enum logic [0:0] {StIdle, StLock} state_e;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("cpu_bus_arbiter: illegal parameter setting");
    end

    function automatic idx_t next_idx(idx_t i);
        return (32'(i) == N_REQ - 1) ? '0 : i + idx_t'(1);
    endfunction

    logic [1:0]  sel_arr  [N_REQ];
    logic [13:0] addr_arr [N_REQ];
    logic [15:0] data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign sel_arr[g]  = REQ_SELECT[2*g +: 2];
        assign addr_arr[g] = REQ_ADDR[14*g +: 14];
        assign data_arr[g] = REQ_DATA[16*g +: 16];
    end

    state_e           state_q, state_d;
    idx_t             ptr_q, ptr_d;
    idx_t             owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             found, accept;
    idx_t             src;

    logic             en_q, we_q;
    logic [1:0]       sel_q;
    logic [13:0]      addr_q;
    logic [15:0]      data_q;

`ifdef CPU_BUS_ARB_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0] wd_q, wd_d;
    logic           flag_q, flag_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        found   = 1'b0;
        src     = owner_q;
        unique case (state_q)
            StIdle: begin
                for (int unsigned k = 0; k < N_REQ; k++) begin
                    int unsigned t;
                    t = 32'(ptr_q) + k;
                    if (t >= N_REQ) t = t - N_REQ;
                    if (!found && REQ_VALID[idx_t'(t)]) begin
                        found = 1'b1;
                        src   = idx_t'(t);
                    end
                end
            end
            StLock: src = owner_q;
            default: ;
        endcase

        // READY is held low while reset is asserted, even with requesters valid.
        REQ_READY = '0;
        if (RST_N && (state_q == StLock || found)) REQ_READY[src] = 1'b1;
        accept = REQ_READY[src] & REQ_VALID[src];

        if (accept && REQ_LAST[src]) begin
            state_d = StIdle;
            grant_d = '0;
            ptr_d   = next_idx(src);
        end else if (accept && state_q == StIdle) begin
            state_d      = StLock;
            owner_d      = src;
            grant_d      = '0;
            grant_d[src] = 1'b1;
        end

`ifdef CPU_BUS_ARB_WATCHDOG_EN
        flag_d = flag_q;
        wd_d   = '0;
        if (state_q == StLock && !accept) begin
            if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                state_d = StIdle;
                grant_d = '0;
                ptr_d   = next_idx(owner_q);
                flag_d  = 1'b1;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
`endif
    end

    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
        end
    end

    // Bus payload holds its last value while EN is low.
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            en_q   <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q <= accept;
            if (accept) begin
                we_q   <= REQ_WE[src];
                sel_q  <= sel_arr[src];
                addr_q <= addr_arr[src];
                data_q <= data_arr[src];
            end
        end
    end

`ifdef CPU_BUS_ARB_WATCHDOG_EN
    always_ff @(posedge BUS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_q   <= '0;
            flag_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            flag_q <= flag_d;
        end
    end

    assign TIMEOUT_FLAG = flag_q;
`else
    assign TIMEOUT_FLAG = 1'b0;
`endif

    assign EN          = en_q;
    assign WE          = we_q;
    assign BRAM_SELECT = sel_q;
    assign BRAM_ADDR   = addr_q;
    assign DATA_IN     = data_q;
    assign GRANT       = grant_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: directed test-plan cases plus random bursts
// checked against a queue-based round-robin reference model.
module tb_cpu_bus_arbiter;

    localparam int N  = 2;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_last, req_we, grant;
    logic [2*N-1:0]  req_select;
    logic [14*N-1:0] req_addr;
    logic [16*N-1:0] req_data;
    logic            en, we, timeout_flag;
    logic [1:0]      bram_select;
    logic [13:0]     bram_addr;
    logic [15:0]     data_in;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .BUS_CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_LAST(req_last),
        .REQ_WE(req_we), .REQ_SELECT(req_select), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .EN(en), .WE(we), .BRAM_SELECT(bram_select), .BRAM_ADDR(bram_addr),
        .DATA_IN(data_in), .GRANT(grant), .TIMEOUT_FLAG(timeout_flag)
    );

    typedef struct packed {
        logic        last;
        logic        we;
        logic [1:0]  sel;
        logic [13:0] addr;
        logic [15:0] data;
    } beat_t;

    typedef struct packed {
        logic         en;
        beat_t        pay;
        logic [N-1:0] grant;
        logic         flag;
    } exp_t;

    beat_t        rq [N][$];
    exp_t         exp_q[$];
    logic [N-1:0] hold, pause;

    // Reference model: plain round-robin bookkeeping.
    int    m_ptr, m_owner, m_idle;
    bit    m_locked, m_flag;
    beat_t m_last;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_idle = 0; m_locked = 0; m_flag = 0; m_last = '0;
        hold = '0; pause = '0;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_q.delete();
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_burst(input int r, input int len, input logic [13:0] base, input bit rnd);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            x.last = (b == len - 1);
            x.we   = rnd ? 1'($urandom) : 1'b1;
            x.sel  = rnd ? 2'($urandom) : 2'd1;
            x.addr = rnd ? 14'($urandom) : base + 14'(b);
            x.data = 16'($urandom);
            rq[r].push_back(x);
        end
    endtask

    task automatic run_cycles(input int n, input int gap_pct, input bit refill);
        for (int c = 0; c < n; c++) begin
            logic [N-1:0] v, exp_ready, acc;
            int           w;
            exp_t         e;
            beat_t        b;
            if (refill)
                for (int i = 0; i < N; i++)
                    if (rq[i].size() == 0) push_burst(i, $urandom_range(1, 4), '0, 1'b1);
            @(negedge clk);
            v = '0;
            for (int i = 0; i < N; i++) begin
                b = (rq[i].size() > 0) ? rq[i][0] : beat_t'($urandom);
                if (rq[i].size() > 0 && !pause[i] &&
                    (hold[i] || $urandom_range(99) >= gap_pct)) v[i] = 1'b1;
                req_last[i]          = b.last;
                req_we[i]            = b.we;
                req_select[2*i +: 2] = b.sel;
                req_addr[14*i +: 14] = b.addr;
                req_data[16*i +: 16] = b.data;
            end
            req_valid = v;
            #1;
            exp_ready = '0;
            w = -1;
            if (m_locked) begin
                exp_ready[m_owner] = 1'b1;
                if (v[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                if (w >= 0) exp_ready[w] = 1'b1;
            end
            check("ready", 32'(req_ready), 32'(exp_ready));
            acc = '0;
            if (w >= 0) begin
                acc[w] = 1'b1;
                m_last = rq[w][0];
                m_idle = 0;
                if (m_last.last) begin
                    m_locked = 0;
                    m_ptr    = (w + 1) % N;
                end else if (!m_locked) begin
                    m_locked = 1;
                    m_owner  = w;
                end
            end else if (m_locked) begin
`ifdef CPU_BUS_ARB_WATCHDOG_EN
                m_idle++;
                if (m_idle == TO) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % N;
                    m_flag   = 1;
                    m_idle   = 0;
                end
`endif
            end
            e.en    = (w >= 0);
            e.pay   = m_last;
            e.grant = m_locked ? (N'(1) << m_owner) : '0;
            e.flag  = m_flag;
            exp_q.push_back(e);
            for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
            hold = v & ~acc;
        end
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (any_pending() && c < 60) begin
            run_cycles(1, 0, 1'b0);
            c++;
        end
        checks++;
        if (any_pending()) begin
            errors++;
            $display("FAIL drain_%s: got beats pending after %0d cycles required none", name, c);
        end
    endtask

    // Monitor: pops one expectation per cycle, after the registered outputs update.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("en", 32'(en), 32'(e.en));
                check("we", 32'(we), 32'(e.pay.we));
                check("select", 32'(bram_select), 32'(e.pay.sel));
                check("addr", 32'(bram_addr), 32'(e.pay.addr));
                check("data", 32'(data_in), 32'(e.pay.data));
                check("grant", 32'(grant), 32'(e.grant));
                check("flag", 32'(timeout_flag), 32'(e.flag));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, 32'(en), 0);
        check({tag, "_we"}, 32'(we), 0);
        check({tag, "_sel"}, 32'(bram_select), 0);
        check({tag, "_addr"}, 32'(bram_addr), 0);
        check({tag, "_data"}, 32'(data_in), 0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_flag"}, 32'(timeout_flag), 0);
    endtask

    initial begin
        beat_t x;
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_we = '0;
        req_select = '0; req_addr = '0; req_data = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single write from req0.
        x = '{last: 1'b1, we: 1'b1, sel: 2'd2, addr: 14'h0123, data: 16'hBEEF};
        rq[0].push_back(x);
        run_cycles(3, 0, 1'b0);

        // Both requesters with single beats: alternation.
        for (int k = 0; k < 2; k++) begin
            push_burst(0, 1, 14'h0200 + 14'(k), 1'b0);
            push_burst(1, 1, 14'h0300 + 14'(k), 1'b0);
        end
        drain("alternate");

        // req1 locked burst while req0 waits.
        push_burst(1, 4, 14'h0010, 1'b0);
        run_cycles(1, 0, 1'b0);
        push_burst(0, 1, 14'h0020, 1'b0);
        drain("burst");
        run_cycles(1, 0, 1'b0);

        // Read at the top address.
        x = '{last: 1'b1, we: 1'b0, sel: 2'd3, addr: 14'h3FFF, data: 16'h1234};
        rq[0].push_back(x);
        run_cycles(2, 0, 1'b0);

        // Reset after 2 of 4 burst beats.
        push_burst(1, 4, 14'h0040, 1'b0);
        run_cycles(2, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push_burst(1, 4, 14'h0050, 1'b0);
        drain("after_reset");

`ifdef CPU_BUS_ARB_WATCHDOG_EN
        // Abandoned lock is released after TO idle cycles; flag stays set.
        push_burst(0, 2, 14'h0060, 1'b0);
        run_cycles(1, 0, 1'b0);
        pause[0] = 1'b1;
        push_burst(1, 1, 14'h0070, 1'b0);
        run_cycles(TO + 2, 0, 1'b0);
        pause[0] = 1'b0;
        drain("watchdog");
`endif

        // Random bursts with random gaps.
        run_cycles(400, 30, 1'b1);
        drain("random");
        run_cycles(2, 0, 1'b0);
        @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares the single CPU-bus BRAM write/read port (BUS_CLK, EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN) between N_REQ internal requesters, e.g. a config loader and a debug writer.
- Arbitration is round-robin. A requester may lock the bus for a multi-beat burst.
- The block is the master driving the slave_port signal set consumed by the BRAM bank.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 256, idle cycles allowed inside a locked burst before forced release. Used only with the optional feature.

Ports:
- BUS_CLK  input  1  single clock for all logic.
- RST_N  input  1  asynchronous, active-low reset.
- REQ_VALID  input  N_REQ  per-requester beat valid.
- REQ_READY  output  N_REQ  per-requester beat accept (combinational).
- REQ_LAST  input  N_REQ  beat is last of burst. A single beat has LAST=1.
- REQ_WE  input  N_REQ  write enable per requester.
- REQ_SELECT  input  2*N_REQ  BRAM select, requester i at [2i+1:2i].
- REQ_ADDR  input  14*N_REQ  BRAM address, requester i at [14i+13:14i].
- REQ_DATA  input  16*N_REQ  write data, requester i at [16i+15:16i].
- EN  output  1  bus enable, registered.
- WE  output  1  bus write enable, registered.
- BRAM_SELECT  output  2  registered.
- BRAM_ADDR  output  14  registered.
- DATA_IN  output  16  registered.
- GRANT  output  N_REQ  one-hot owner while locked; 0 in IDLE.
- TIMEOUT_FLAG  output  1  sticky forced-release indicator.

Behaviour:
- Reset: state=IDLE, pointer=0, owner=0, REQ_READY=0, GRANT=0, EN=0, WE=0, BRAM_SELECT=0, BRAM_ADDR=0, DATA_IN=0, TIMEOUT_FLAG=0.
- Reset mid-burst aborts the burst immediately. No partial-state recovery.
- IDLE state:
  - Winner w = first i with REQ_VALID[i]=1, searching from pointer upward with wrap at N_REQ-1 -> 0.
  - REQ_READY[w]=1 in the same cycle; the beat is accepted.
  - If REQ_LAST[w]=1: stay IDLE, pointer <= (w+1) mod N_REQ.
  - Else: go to LOCK, owner <= w, GRANT <= onehot(w).
  - No valid requester: nothing happens and pointer holds.
- LOCK state:
  - REQ_READY[owner]=1. All other READY bits are 0.
  - Beats are accepted whenever REQ_VALID[owner]=1.
  - Accepted beat with LAST=1: go to IDLE, GRANT<=0, pointer <= (owner+1) mod N_REQ.
  - Other requesters' VALID are ignored (they wait, no drop).
- Handshake:
  - A beat transfers on VALID&READY.
  - Requesters hold payload stable while VALID=1 and READY=0.
- Output latency:
  - An accepted beat in cycle t drives EN=1 and WE/BRAM_SELECT/BRAM_ADDR/DATA_IN from that beat in cycle t+1.
  - EN=0 in any cycle following no acceptance. Address/data/select hold their last values when EN=0.
  - WE=0 beats (reads) propagate with EN=1, WE=0.
  - Throughput: one beat per cycle, including back-to-back bursts from different owners.
- Fairness: a requester that just finished is lowest priority next arbitration. With all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0.
- Simultaneous events:
  - LAST beat in LOCK and a new VALID from another requester in the same cycle: the new requester is not served that cycle. It is arbitrated in the next cycle (IDLE).
  - Payload is not checked; LAST with VALID=0 is ignored.

Optional Feature:
- Macro: CPU_BUS_ARB_WATCHDOG_EN.
- When defined:
  - In LOCK, a counter increments each cycle with REQ_VALID[owner]=0 and clears on any accepted beat.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, GRANT<=0, pointer <= owner+1, TIMEOUT_FLAG<=1.
  - TIMEOUT_FLAG is sticky until RST_N. No bus beat is emitted for the release.
- When undefined: the lock is held indefinitely, no counter exists, and TIMEOUT_FLAG is tied 0.

Test Plan:
- Single write, req0 VALID=1 LAST=1 WE=1 SEL=2 ADDR=0x0123 DATA=0xBEEF -> READY[0]=1 same cycle; next cycle EN=1 WE=1 BRAM_SELECT=2 BRAM_ADDR=0x0123 DATA_IN=0xBEEF; following cycle EN=0.
- Both requesters continuously valid, single beats -> accepted order 0,1,0,1; EN=1 every cycle after first; pointer alternates.
- req1 4-beat burst (ADDR 0x10..0x13) while req0 valid throughout -> GRANT=2'b10 for beats 2-4, READY[0]=0 until req1 LAST accepted; req0 served the next cycle; bus shows 0x10,0x11,0x12,0x13 then req0's beat.
- Read beat, WE=0 ADDR=0x3FFF (top address) -> EN=1 WE=0 BRAM_ADDR=0x3FFF one cycle later.
- RST_N asserted low mid-burst (after 2 of 4 beats) -> all outputs 0 immediately; after release, state IDLE, pointer=0, req1 re-arbitrated fresh.
- CPU_BUS_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=4: req0 sends 1 non-LAST beat, then VALID=0 -> after 4 idle cycles GRANT=0, TIMEOUT_FLAG=1; pending req1 is granted next cycle; TIMEOUT_FLAG stays 1 until reset.
